// File: rtl/ram3d_block_ring_ctrl.sv
// Circular block-FIFO sequencer for a P-slot dual-port block RAM (producer -> consumer).
// Optional macro RAM3D_RING_OVERWRITE_EN: writes to a full ring overwrite the oldest block.
module ram3d_block_ring_ctrl #(
   parameter int P  = 2,
   parameter int AW = $clog2(P),
   parameter int CW = $clog2(P + 1)
) (
   input  logic          clock,
   input  logic          i_rst_n,
   input  logic          i_clear,
   input  logic          i_wr_valid,
   output logic          o_wr_ready,
   input  logic          i_rd_req,
   output logic          o_rd_valid,
   output logic [AW-1:0] o_rd_slot,
   output logic          o_ram_wenable,
   output logic          o_ram_enable,
   output logic [AW-1:0] o_ram_write_addr,
   output logic [AW-1:0] o_ram_read_addr,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_drop
);

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rdValid_q;
   logic [AW-1:0] rdSlot_q;
   logic          full, empty, wrReady, wrFire, rdFire, dropEvent;

   // Slot count need not be a power of two, so wrap explicitly at P-1.
   function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
      return (p == AW'(P - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full  = (count_q == CW'(P));
   assign empty = (count_q == '0);

`ifdef RAM3D_RING_OVERWRITE_EN
   logic drop_q;

   assign wrReady   = i_rst_n;
   assign dropEvent = wrFire & full & ~rdFire;

   always_ff @(posedge clock or negedge i_rst_n) begin
      if (!i_rst_n) drop_q <= 1'b0;
      else          drop_q <= dropEvent;
   end

   assign o_drop = drop_q;
`else
   assign wrReady   = ~full;
   assign dropEvent = 1'b0;
   assign o_drop    = 1'b0;
`endif

   assign wrFire = i_wr_valid & wrReady & ~i_clear;
   assign rdFire = i_rd_req & ~empty & ~i_clear;

   assign o_wr_ready       = wrReady;
   assign o_ram_wenable    = wrFire;
   assign o_ram_enable     = wrFire | rdFire;
   assign o_ram_write_addr = wrPtr_q;
   assign o_ram_read_addr  = rdPtr_q;
   assign o_count          = count_q;
   assign o_full           = full;
   assign o_empty          = empty;
   assign o_rd_valid       = rdValid_q;
   assign o_rd_slot        = rdSlot_q;

   // An overwrite drags the read pointer along so the oldest surviving block stays at its head.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (i_clear) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (wrFire)             wrPtr_d = nextPtr(wrPtr_q);
         if (rdFire | dropEvent) rdPtr_d = nextPtr(rdPtr_q);
         if (wrFire & ~rdFire & ~dropEvent) count_d = count_q + CW'(1);
         else if (rdFire & ~wrFire)         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         rdValid_q <= 1'b0;
         rdSlot_q  <= '0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         rdValid_q <= rdFire;
         if (rdFire) rdSlot_q <= rdPtr_q;
      end
   end

endmodule
